// File: rtl/hba_quadn.sv
// hba_quadn: HBA bus slave with NUM_CH x4 quadrature counters, snapshot shadows and change interrupt.
// Define HBA_QUADN_FILTER_EN to add a FILT_LEN-cycle stability filter after the pin synchronisers.
module hba_quadn #(
    parameter int DBUS_WIDTH        = 8,
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
    parameter int PERIPH_ADDR       = 0,
    parameter int NUM_CH            = 2,
    parameter int CNT_BYTES         = 2,
    parameter int FILT_LEN          = 3
) (
    input  logic                  hba_clk,
    input  logic                  hba_reset,
    input  logic                  hba_rnw,
    input  logic                  hba_select,
    input  logic [ADDR_WIDTH-1:0] hba_abus,
    input  logic [DBUS_WIDTH-1:0] hba_dbus,
    output logic [DBUS_WIDTH-1:0] hba_dbus_slave,
    output logic                  hba_xferack_slave,
    output logic                  slave_interrupt,
    input  logic [NUM_CH-1:0]     quad_enc_a,
    input  logic [NUM_CH-1:0]     quad_enc_b
);
    localparam int W = 8 * CNT_BYTES;
    localparam logic [REG_ADDR_WIDTH-1:0] A_CHEN = REG_ADDR_WIDTH'(0);
    localparam logic [REG_ADDR_WIDTH-1:0] A_CTRL = REG_ADDR_WIDTH'(1);
    localparam logic [REG_ADDR_WIDTH-1:0] A_CHG  = REG_ADDR_WIDTH'(2);
    localparam logic [REG_ADDR_WIDTH-1:0] A_ERR  = REG_ADDR_WIDTH'(3);

    logic [2*NUM_CH-1:0] r_pin_p0, r_pin_p1;
    logic [2*NUM_CH-1:0] w_pin;
    logic [NUM_CH-1:0]   w_a, w_b, r_st_a, r_st_b;
    logic [NUM_CH-1:0]   w_da, w_db, w_illegal, w_step, w_up, w_errclr;
    logic [NUM_CH-1:0]   r_ch_en, r_changed, r_err;
    logic [W-1:0]        r_cnt    [NUM_CH];
    logic [W-1:0]        r_shadow [NUM_CH];
    logic                r_intr_en, r_busy;
    logic                w_hit, w_decode, w_wr, w_snap, w_clr;
    logic [REG_ADDR_WIDTH-1:0] w_reg;
    logic [DBUS_WIDTH-1:0]     w_rdata;
    logic                      w_unused_dbus;

    // Two-flop synchroniser for all pins, packed as {B, A}
    always_ff @(posedge hba_clk or posedge hba_reset) begin
        if (hba_reset) begin
            r_pin_p0 <= '0;
            r_pin_p1 <= '0;
        end else begin
            r_pin_p0 <= {quad_enc_b, quad_enc_a};
            r_pin_p1 <= r_pin_p0;
        end
    end

`ifdef HBA_QUADN_FILTER_EN
    logic [2*NUM_CH-1:0] r_filt;
    logic [3:0]          r_fcnt [2*NUM_CH];

    always_ff @(posedge hba_clk or posedge hba_reset) begin
        if (hba_reset) begin
            r_filt <= '0;
            for (int i = 0; i < 2*NUM_CH; i++) r_fcnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2*NUM_CH; i++) begin
                if (r_pin_p1[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == 4'(FILT_LEN - 1)) begin
                    r_filt[i] <= r_pin_p1[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 4'd1;
                end
            end
        end
    end
    assign w_pin = r_filt;
`else
    assign w_pin = r_pin_p1;
`endif

    assign w_a = w_pin[NUM_CH-1:0];
    assign w_b = w_pin[2*NUM_CH-1:NUM_CH];

    // Exactly one input changed -> a step; A_new ^ B_old gives the forward direction
    assign w_da      = w_a ^ r_st_a;
    assign w_db      = w_b ^ r_st_b;
    assign w_illegal = w_da & w_db;
    assign w_up      = w_a ^ r_st_b;

    assign w_hit    = hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == PERIPH_ADDR_WIDTH'(PERIPH_ADDR);
    assign w_decode = hba_select & w_hit & ~r_busy;
    assign w_wr     = w_decode & ~hba_rnw;
    assign w_reg    = hba_abus[REG_ADDR_WIDTH-1:0];
    assign w_snap   = w_wr && (w_reg == A_CTRL) && hba_dbus[1];
    assign w_clr    = w_wr && (w_reg == A_CTRL) && hba_dbus[2];
    assign w_errclr = (w_wr && (w_reg == A_ERR)) ? hba_dbus[NUM_CH-1:0] : '0;
    assign w_step   = (w_da ^ w_db) & r_ch_en & ~{NUM_CH{w_clr}};
    assign w_unused_dbus = ^hba_dbus;

    assign slave_interrupt = r_intr_en & (|r_changed);

    always_comb begin
        w_rdata = '0;
        if (w_reg == A_CHEN) w_rdata = DBUS_WIDTH'(r_ch_en);
        if (w_reg == A_CTRL) w_rdata = DBUS_WIDTH'(r_intr_en);
        if (w_reg == A_CHG)  w_rdata = DBUS_WIDTH'(r_changed);
        if (w_reg == A_ERR)  w_rdata = DBUS_WIDTH'(r_err);
        for (int n = 0; n < NUM_CH; n++) begin
            for (int k = 0; k < CNT_BYTES; k++) begin
                if (w_reg == REG_ADDR_WIDTH'(4 + n*CNT_BYTES + k)) w_rdata = r_shadow[n][8*k +: 8];
            end
        end
    end

    always_ff @(posedge hba_clk or posedge hba_reset) begin
        if (hba_reset) begin
            r_st_a            <= '0;
            r_st_b            <= '0;
            r_ch_en           <= '0;
            r_changed         <= '0;
            r_err             <= '0;
            r_intr_en         <= 1'b0;
            r_busy            <= 1'b0;
            hba_xferack_slave <= 1'b0;
            hba_dbus_slave    <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                r_cnt[n]    <= '0;
                r_shadow[n] <= '0;
            end
        end else begin
            r_st_a            <= w_a;
            r_st_b            <= w_b;
            r_busy            <= hba_select & (r_busy | w_hit);
            hba_xferack_slave <= w_decode;
            hba_dbus_slave    <= (w_decode & hba_rnw) ? w_rdata : '0;
            if (w_wr && (w_reg == A_CHEN)) r_ch_en   <= hba_dbus[NUM_CH-1:0];
            if (w_wr && (w_reg == A_CTRL)) r_intr_en <= hba_dbus[0];
            r_err     <= (r_err & ~w_errclr) | w_illegal;
            r_changed <= w_step | (w_snap ? '0 : r_changed);
            // Shadow captures the pre-update count; CLR overrides any same-cycle step
            for (int n = 0; n < NUM_CH; n++) begin
                if (w_snap) r_shadow[n] <= r_cnt[n];
                if (w_clr) begin
                    r_cnt[n] <= '0;
                end else if (w_step[n]) begin
                    r_cnt[n] <= w_up[n] ? r_cnt[n] + W'(1) : r_cnt[n] - W'(1);
                end
            end
        end
    end
endmodule
